// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types for the SPI command sequencer: FSM state encoding,
// the write opcode and the LEN/remaining counter width.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_SKIP
  } state_t;

  localparam logic [7:0]  OPC_WRITE = 8'h02;
  localparam int unsigned LEN_W     = 8;

  typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Bundle of SPI receive-buffer inputs and register-bus / status outputs.
// slave : the sequencer itself.  master : the surrounding environment.
interface spi_cmd_sequencer_if;

  logic [7:0] SPI_BYTE;
  logic       SPI_CHANGED;
  logic       SPI_CS;
  logic       WR_EN;
  logic       WR_READY;
  logic [7:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       CMD_VALID;
  logic [7:0] CMD_OPCODE;
  logic       BUSY;
  logic       ERR;

  modport slave (
    input  SPI_BYTE, SPI_CHANGED, SPI_CS, WR_READY,
    output WR_EN, WR_ADDR, WR_DATA, CMD_VALID, CMD_OPCODE, BUSY, ERR
  );

  modport master (
    output SPI_BYTE, SPI_CHANGED, SPI_CS, WR_READY,
    input  WR_EN, WR_ADDR, WR_DATA, CMD_VALID, CMD_OPCODE, BUSY, ERR
  );

endinterface

// File: rtl/spi_cmd_sequencer_sync.sv
// spi_cdc_sync: STAGES-deep single-bit synchronizer with a selectable
// reset value (chip select resets to deselected).
module spi_cdc_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {STAGES{RESET_VAL}};
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: parses [OPCODE][ADDR][LEN][DATA x LEN] frames from the
// SPI receive buffer into register-bus writes or single command strobes.
// Optional feature macro: SPI_CMD_TIMEOUT_EN (inter-byte timeout in a frame).
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              RST_N,
  spi_cmd_sequencer_if.slave bus
);

  state_t     state, state_next;
  logic       chg_s, chg_d, cs_s, byte_evt, wr_accept, byte_state;
  logic       wr_en, err, cmd_valid, tmo_hit;
  logic [7:0] wr_addr, wr_data, cmd_opcode, addr;
  len_t       remaining;
  logic       err_set, err_clr, cmd_pulse, opc_load, addr_load, len_load, data_load;

  spi_cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_chg_sync (
    .clk(CLK), .rst_n(RST_N), .d(bus.SPI_CHANGED), .q(chg_s)
  );

  spi_cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(CLK), .rst_n(RST_N), .d(bus.SPI_CS), .q(cs_s)
  );

  // Delayed copy of the synced byte strobe for rising-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) chg_d <= 1'b0;
    else        chg_d <= chg_s;
  end

  assign byte_evt   = chg_s & ~chg_d;
  assign wr_accept  = wr_en & bus.WR_READY;
  assign byte_state = state inside {ST_OPCODE, ST_ADDR, ST_LEN, ST_DATA};

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Inter-byte timer: restarts on every byte, runs only mid-frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                                 tmo_cnt <= '0;
    else if (byte_evt || !(state inside {ST_ADDR, ST_LEN, ST_DATA})) tmo_cnt <= '0;
    else if (!tmo_hit)                                          tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state inside {ST_ADDR, ST_LEN, ST_DATA}) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control; CS release outranks everything, then
  // timeout, then overrun (byte arriving while a write is still pending).
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    cmd_pulse  = 1'b0;
    opc_load   = 1'b0;
    addr_load  = 1'b0;
    len_load   = 1'b0;
    data_load  = 1'b0;
    if (cs_s) begin
      state_next = ST_IDLE;
      // DATA is left for DONE as soon as remaining reaches 0, so being in
      // DATA here always means the frame was cut short.
      if (state == ST_DATA) err_set = 1'b1;
    end else if (tmo_hit) begin
      err_set    = 1'b1;
      state_next = ST_SKIP;
    end else if (byte_evt && wr_en && byte_state) begin
      err_set    = 1'b1;
      state_next = ST_SKIP;
    end else begin
      case (state)
        ST_IDLE:   state_next = ST_OPCODE;
        ST_OPCODE: if (byte_evt) begin
          opc_load = 1'b1;
          err_clr  = 1'b1;
          if (bus.SPI_BYTE == OPC_WRITE) begin
            state_next = ST_ADDR;
          end else begin
            cmd_pulse  = 1'b1;
            state_next = ST_SKIP;
          end
        end
        ST_ADDR: if (byte_evt) begin
          addr_load  = 1'b1;
          state_next = ST_LEN;
        end
        ST_LEN: if (byte_evt) begin
          if (bus.SPI_BYTE == 8'h00) begin
            state_next = ST_DONE;
          end else if (bus.SPI_BYTE <= len_t'(MAX_LEN)) begin
            len_load   = 1'b1;
            state_next = ST_DATA;
          end else begin
            err_set    = 1'b1;
            state_next = ST_SKIP;
          end
        end
        ST_DATA: begin
          if (byte_evt) data_load = 1'b1;
          if (wr_accept && remaining == len_t'(1)) state_next = ST_DONE;
        end
        default: state_next = state;
      endcase
    end
  end

  // Write handshake, address/length bookkeeping, status and command outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      addr       <= '0;
      remaining  <= '0;
      err        <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= '0;
    end else begin
      if (data_load) begin
        wr_en   <= 1'b1;
        wr_addr <= addr;
        wr_data <= bus.SPI_BYTE;
      end else if (wr_accept) begin
        wr_en <= 1'b0;
      end
      if (addr_load)                          addr <= bus.SPI_BYTE;
      else if (state == ST_DATA && wr_accept) addr <= addr + 8'd1;
      if (len_load)                           remaining <= bus.SPI_BYTE;
      else if (state == ST_DATA && wr_accept) remaining <= remaining - len_t'(1);
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      cmd_valid <= cmd_pulse;
      if (opc_load) cmd_opcode <= bus.SPI_BYTE;
    end
  end

  assign bus.WR_EN      = wr_en;
  assign bus.WR_ADDR    = wr_addr;
  assign bus.WR_DATA    = wr_data;
  assign bus.CMD_VALID  = cmd_valid;
  assign bus.CMD_OPCODE = cmd_opcode;
  assign bus.ERR        = err;
  assign bus.BUSY       = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer: directed frames plus random frames,
// checked against a frame-level reference model.
module tb_spi_cmd_sequencer;

  logic CLK;
  logic RST_N;
  spi_cmd_sequencer_if bus ();

  spi_cmd_sequencer #(
    .SYNC_STAGES(2),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(4096)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] wr_log[$];
  int          cmd_cnt = 0;

  // Record every accepted write and every command strobe cycle.
  always @(posedge CLK) begin
    if (RST_N && bus.WR_EN && bus.WR_READY) wr_log.push_back({bus.WR_ADDR, bus.WR_DATA});
    if (RST_N && bus.CMD_VALID) cmd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.SPI_BYTE    = b;
    bus.SPI_CHANGED = 1'b1;
    repeat (6) @(negedge CLK);
    bus.SPI_CHANGED = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic cs_low();
    bus.SPI_CS = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic cs_high();
    bus.SPI_CS = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  logic [7:0]  frame[$];
  logic [15:0] exp_wr[$];
  logic        exp_err_pre, exp_err_post;
  int          exp_cmd;

  // Frame-level model, WR_READY held high: derive writes, strobes and ERR.
  task automatic model_frame();
    logic [7:0] op, a, len;
    int nd, n;
    exp_wr.delete();
    exp_err_pre  = 1'b0;
    exp_err_post = 1'b0;
    exp_cmd      = 0;
    op = frame[0];
    if (op != 8'h02) begin
      exp_cmd = 1;
    end else if (frame.size() >= 3) begin
      a   = frame[1];
      len = frame[2];
      if (len > 16) begin
        exp_err_pre  = 1'b1;
        exp_err_post = 1'b1;
      end else if (len != 0) begin
        nd = frame.size() - 3;
        n  = (nd < int'(len)) ? nd : int'(len);
        for (int i = 0; i < n; i++) exp_wr.push_back({8'(a + 8'(i)), frame[3+i]});
        exp_err_post = (nd < int'(len));
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int base_w, base_c;
    model_frame();
    base_w = wr_log.size();
    base_c = cmd_cnt;
    cs_low();
    foreach (frame[i]) send_byte(frame[i]);
    chk({tag, " busy_in_frame"}, 32'(bus.BUSY), 32'd1);
    chk({tag, " err_before_cs"}, 32'(bus.ERR), 32'(exp_err_pre));
    cs_high();
    chk({tag, " busy_after_cs"}, 32'(bus.BUSY), 32'd0);
    chk({tag, " err_after_cs"}, 32'(bus.ERR), 32'(exp_err_post));
    chk({tag, " wr_en_idle"}, 32'(bus.WR_EN), 32'd0);
    chk({tag, " cmd_pulses"}, 32'(cmd_cnt - base_c), 32'(exp_cmd));
    chk({tag, " cmd_opcode"}, 32'(bus.CMD_OPCODE), 32'(frame[0]));
    chk({tag, " wr_count"}, 32'(wr_log.size() - base_w), 32'(exp_wr.size()));
    foreach (exp_wr[i]) chk({tag, " wr_addr_data"}, 32'(wr_log[base_w + i]), 32'(exp_wr[i]));
  endtask

  initial begin
    int base_w;
    logic [7:0] op;
    logic [7:0] len;
    int nd;

    RST_N           = 1'b0;
    bus.SPI_CS      = 1'b1;
    bus.SPI_CHANGED = 1'b0;
    bus.SPI_BYTE    = 8'h00;
    bus.WR_READY    = 1'b1;
    repeat (4) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset wr_en", 32'(bus.WR_EN), 32'd0);
    chk("reset busy", 32'(bus.BUSY), 32'd0);
    chk("reset err", 32'(bus.ERR), 32'd0);
    chk("reset cmd_valid", 32'(bus.CMD_VALID), 32'd0);
    chk("reset cmd_opcode", 32'(bus.CMD_OPCODE), 32'd0);
    chk("reset wr_addr", 32'(bus.WR_ADDR), 32'd0);

    frame = '{8'h02, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_frame("basic");
    frame = '{8'h02, 8'hFF, 8'h02, 8'h11, 8'h22};
    run_frame("wrap");
    frame = '{8'h5A, 8'h01};
    run_frame("cmd");
    frame = '{8'h02, 8'h00, 8'h14};
    run_frame("len_over");
    frame = '{8'h02, 8'h00, 8'h01, 8'h77};
    run_frame("err_clear");

    // Overrun: write held by WR_READY=0, next data byte must be dropped.
    base_w = wr_log.size();
    bus.WR_READY = 1'b0;
    cs_low();
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h02); send_byte(8'h01);
    chk("ovr wr_en_held", 32'(bus.WR_EN), 32'd1);
    chk("ovr wr_addr", 32'(bus.WR_ADDR), 32'h20);
    chk("ovr err_before", 32'(bus.ERR), 32'd0);
    send_byte(8'h02);
    chk("ovr err_set", 32'(bus.ERR), 32'd1);
    chk("ovr wr_data_stable", 32'(bus.WR_DATA), 32'h01);
    bus.WR_READY = 1'b1;
    repeat (8) @(negedge CLK);
    chk("ovr wr_en_drop", 32'(bus.WR_EN), 32'd0);
    cs_high();
    chk("ovr wr_count", 32'(wr_log.size() - base_w), 32'd1);
    chk("ovr wr_entry", 32'(wr_log[base_w]), 32'h2001);
    chk("ovr err_sticky", 32'(bus.ERR), 32'd1);

    frame = '{8'h02, 8'h30, 8'h04, 8'h01};
    run_frame("cs_cut");

    // Asynchronous reset in the middle of DATA with a pending write.
    bus.WR_READY = 1'b0;
    cs_low();
    send_byte(8'h02); send_byte(8'h40); send_byte(8'h02); send_byte(8'h55);
    chk("rst pend_wr_en", 32'(bus.WR_EN), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rst async wr_en", 32'(bus.WR_EN), 32'd0);
    chk("rst async busy", 32'(bus.BUSY), 32'd0);
    chk("rst async opcode", 32'(bus.CMD_OPCODE), 32'd0);
    chk("rst async wr_data", 32'(bus.WR_DATA), 32'd0);
    bus.SPI_CS   = 1'b1;
    bus.WR_READY = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rst release busy", 32'(bus.BUSY), 32'd0);

    // Random frames against the model.
    for (int f = 0; f < 24; f++) begin
      frame.delete();
      if ($urandom_range(0, 3) != 0) begin
        op = 8'h02;
      end else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h02) op = 8'hA5;
      end
      frame.push_back(op);
      if (op == 8'h02) begin
        frame.push_back(8'($urandom_range(0, 255)));
        len = 8'($urandom_range(0, 20));
        frame.push_back(len);
        nd = (len > 16) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, int'(len) + 1));
        for (int i = 0; i < nd; i++) frame.push_back(8'($urandom_range(0, 255)));
      end else begin
        frame.push_back(8'($urandom_range(0, 255)));
      end
      run_frame("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
